// File: rtl/result_writeback_master.sv
// Avalon-MM write master that snapshots DEPTH results plus their sum
// and writes them back as DEPTH+1 single-beat word writes, sum last.
module result_writeback_master #(
  parameter int DEPTH      = 8,
  parameter int RES_WIDTH  = 24,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [RES_WIDTH-1:0]    c_vector [0:DEPTH-1],
  input  logic [RES_WIDTH-1:0]    sum,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_write,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    wb_done
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RES_WIDTH-1:0]  cap_c_q [0:DEPTH-1];
  logic [RES_WIDTH-1:0]  cap_c_d [0:DEPTH-1];
  logic [RES_WIDTH-1:0]  cap_sum_q, cap_sum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic [IDX_W-1:0]      nxt_idx;
  logic [RES_WIDTH-1:0]  nxt_res;

  assign accept  = write_q & ~avm_waitrequest;
  assign nxt_idx = idx_q + IDX_W'(1);

  // Element for the beat after the current one; sum once past the results
  always_comb begin
    nxt_res = cap_sum_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (nxt_idx == IDX_W'(i)) begin
        nxt_res = cap_c_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_c_d   = cap_c_q;
    cap_sum_d = cap_sum_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    busy_d    = busy_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          cap_c_d   = c_vector;
          cap_sum_d = sum;
          idx_d     = '0;
          addr_d    = BASE_ADDR;
          data_d    = DATA_WIDTH'(c_vector[0]);
          write_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          if (idx_q == LAST) begin
            write_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d  = nxt_idx;
            addr_d = addr_q + STEP;
            data_d = DATA_WIDTH'(nxt_res);
          end
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cap_c_q   <= '{default: '0};
      cap_sum_q <= '0;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_c_q   <= cap_c_d;
      cap_sum_q <= cap_sum_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign avm_write      = write_q;
  assign avm_byteenable = '1;
  assign busy           = busy_q;
  assign wb_done        = done_q;

endmodule

// File: tb/tb_result_writeback_master.sv
// Self-checking bench for result_writeback_master: three instances
// (base 0, base 0x1000, base near the top of the address space).
module tb_result_writeback_master;

  localparam int DEPTH = 8;
  localparam int RW    = 24;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_1000;
  localparam logic [31:0] BASE_C = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic wr;
  logic [RW-1:0] c_vector [0:DEPTH-1];
  logic [RW-1:0] sum;

  logic [31:0] addr_a, data_a, addr_b, data_b, addr_c, data_c;
  logic [3:0]  be_a, be_b, be_c;
  logic        write_a, write_b, write_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  int checks = 0;
  int failures = 0;

  logic [31:0] ga_addr[$], ga_data[$];
  logic [31:0] gb_addr[$], gb_data[$];
  logic [31:0] gc_addr[$], gc_data[$];
  int done_cyc, done_cnt, busy_cnt, stall_cnt;
  int unstable, be_bad, hold8;
  logic busy_after;
  logic [RW-1:0] ref_c [0:DEPTH-1];
  logic [RW-1:0] ref_sum;

  always #5 clk = ~clk;

  result_writeback_master #(.BASE_ADDR(BASE_A)) u_a (
    .clk(clk), .rst(rst), .start(start),
    .c_vector(c_vector), .sum(sum),
    .avm_address(addr_a), .avm_write(write_a),
    .avm_writedata(data_a), .avm_byteenable(be_a),
    .avm_waitrequest(wr), .busy(busy_a), .wb_done(done_a)
  );

  result_writeback_master #(.BASE_ADDR(BASE_B)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .c_vector(c_vector), .sum(sum),
    .avm_address(addr_b), .avm_write(write_b),
    .avm_writedata(data_b), .avm_byteenable(be_b),
    .avm_waitrequest(wr), .busy(busy_b), .wb_done(done_b)
  );

  result_writeback_master #(.BASE_ADDR(BASE_C)) u_c (
    .clk(clk), .rst(rst), .start(start),
    .c_vector(c_vector), .sum(sum),
    .avm_address(addr_c), .avm_write(write_c),
    .avm_writedata(data_c), .avm_byteenable(be_c),
    .avm_waitrequest(wr), .busy(busy_c), .wb_done(done_c)
  );

  task automatic rand_data();
    for (int i = 0; i < DEPTH; i++) c_vector[i] = 24'($urandom());
    sum = 24'($urandom());
  endtask

  // Start is sampled at the following edge (edge 0); returns at edge0+1
  task automatic pulse_start();
    ref_c   = c_vector;
    ref_sum = sum;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Cycle n spans edge n-1 .. edge n; inputs driven after edge n-1,
  // outputs sampled on the falling edge of cycle n.
  task automatic run_xfer(input int mode, input int restart_at,
                          input bit scramble, input int tail);
    logic prev_stall;
    logic [31:0] prev_a, prev_d;
    ga_addr.delete(); ga_data.delete();
    gb_addr.delete(); gb_data.delete();
    gc_addr.delete(); gc_data.delete();
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; stall_cnt = 0;
    unstable = 0; be_bad = 0; hold8 = 0; busy_after = 1'bx;
    prev_stall = 1'b0; prev_a = '0; prev_d = '0;
    for (int n = 1; n <= 400; n++) begin
      case (mode)
        1: wr = (n >= 3 && n <= 5) || (n >= 12 && n <= 14);
        2: wr = ($urandom_range(0, 2) == 0);
        default: wr = 1'b0;
      endcase
      if (scramble && n == 1) begin
        for (int i = 0; i < DEPTH; i++) c_vector[i] = 24'hFFFFFF;
        sum = 24'hFFFFFF;
      end
      start = (n == restart_at);
      if (start) rand_data();
      @(negedge clk);
      if (prev_stall && (addr_a !== prev_a || data_a !== prev_d))
        unstable++;
      prev_stall = write_a && wr;
      prev_a = addr_a;
      prev_d = data_a;
      if (write_a && wr) stall_cnt++;
      if (write_a && addr_a == BASE_A + 32'h8) hold8++;
      if (write_a && !wr) begin ga_addr.push_back(addr_a); ga_data.push_back(data_a); end
      if (write_b && !wr) begin gb_addr.push_back(addr_b); gb_data.push_back(data_b); end
      if (write_c && !wr) begin gc_addr.push_back(addr_c); gc_data.push_back(data_c); end
      if ((write_a && be_a !== 4'hF) || (write_b && be_b !== 4'hF) ||
          (write_c && be_c !== 4'hF)) be_bad++;
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (done_cyc != 0 && n == done_cyc + 1) busy_after = busy_a;
      if (done_cyc != 0 && n >= done_cyc + tail) break;
      @(posedge clk); #1;
    end
    wr = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr = 1'b0; sum = '0;
    for (int i = 0; i < DEPTH; i++) c_vector[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({write_a, busy_a, done_a} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000", {write_a, busy_a, done_a});
    end
    checks++;
    if (addr_a !== BASE_A || addr_b !== BASE_B) begin
      failures++; $display("FAIL reset_addr got=%h/%h exp=%h/%h", addr_a, addr_b, BASE_A, BASE_B);
    end
    checks++;
    if (data_a !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", data_a);
    end
    checks++;
    if (be_a !== 4'hF) begin
      failures++; $display("FAIL reset_be got=%h exp=f", be_a);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) c_vector[i] = 24'(i + 1);
    sum = 24'd36;
    pulse_start();
    run_xfer(0, 0, 1'b0, 3);
    checks++;
    if (ga_addr.size() != DEPTH + 1) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", ga_addr.size(), DEPTH + 1);
    end
    for (int i = 0; i < ga_addr.size() && i <= DEPTH; i++) begin
      logic [31:0] ea, ed;
      ea = 32'(4 * i);
      ed = (i < DEPTH) ? 32'(i + 1) : 32'h24;
      checks++;
      if ({ga_addr[i], ga_data[i]} !== {ea, ed}) begin
        failures++; $display("FAIL basic_beat%0d got=%h:%h exp=%h:%h", i, ga_addr[i], ga_data[i], ea, ed);
      end
    end
    checks++;
    if (done_cyc != DEPTH + 2 || done_cnt != 1) begin
      failures++; $display("FAIL basic_done got=cyc%0d/n%0d exp=cyc%0d/n1", done_cyc, done_cnt, DEPTH + 2);
    end
    checks++;
    if (busy_cnt != DEPTH + 2 || busy_after !== 1'b0) begin
      failures++; $display("FAIL basic_busy got=%0d/%b exp=%0d/0", busy_cnt, busy_after, DEPTH + 2);
    end
  endtask

  task automatic test_stall();
    rand_data();
    pulse_start();
    run_xfer(1, 0, 1'b0, 2);
    checks++;
    if (ga_addr.size() != DEPTH + 1) begin
      failures++; $display("FAIL stall_count got=%0d exp=%0d", ga_addr.size(), DEPTH + 1);
    end
    for (int i = 0; i < ga_addr.size() && i <= DEPTH; i++) begin
      logic [31:0] ea, ed;
      ea = BASE_A + 32'(4 * i);
      ed = (i < DEPTH) ? 32'(ref_c[i]) : 32'(ref_sum);
      checks++;
      if ({ga_addr[i], ga_data[i]} !== {ea, ed}) begin
        failures++; $display("FAIL stall_beat%0d got=%h:%h exp=%h:%h", i, ga_addr[i], ga_data[i], ea, ed);
      end
    end
    checks++;
    if (hold8 != 4 || unstable != 0) begin
      failures++; $display("FAIL stall_hold got=%0d/%0d exp=4/0", hold8, unstable);
    end
    checks++;
    if (done_cyc != DEPTH + 8) begin
      failures++; $display("FAIL stall_done got=%0d exp=%0d", done_cyc, DEPTH + 8);
    end
  endtask

  task automatic test_snapshot();
    rand_data();
    pulse_start();
    run_xfer(0, 0, 1'b1, 2);
    checks++;
    if (ga_addr.size() != DEPTH + 1) begin
      failures++; $display("FAIL snap_count got=%0d exp=%0d", ga_addr.size(), DEPTH + 1);
    end
    for (int i = 0; i < ga_data.size() && i <= DEPTH; i++) begin
      logic [31:0] ed;
      ed = (i < DEPTH) ? 32'(ref_c[i]) : 32'(ref_sum);
      checks++;
      if (ga_data[i] !== ed) begin
        failures++; $display("FAIL snap_beat%0d got=%h exp=%h", i, ga_data[i], ed);
      end
    end
  endtask

  task automatic test_start_busy(input int at, input string tag);
    rand_data();
    pulse_start();
    run_xfer(0, at, 1'b0, 4);
    checks++;
    if (ga_addr.size() != DEPTH + 1 || done_cnt != 1) begin
      failures++; $display("FAIL %s_count got=%0d/%0d exp=%0d/1", tag, ga_addr.size(), done_cnt, DEPTH + 1);
    end
    for (int i = 0; i < ga_addr.size() && i <= DEPTH; i++) begin
      logic [31:0] ea, ed;
      ea = BASE_A + 32'(4 * i);
      ed = (i < DEPTH) ? 32'(ref_c[i]) : 32'(ref_sum);
      checks++;
      if ({ga_addr[i], ga_data[i]} !== {ea, ed}) begin
        failures++; $display("FAIL %s_beat%0d got=%h:%h exp=%h:%h", tag, i, ga_addr[i], ga_data[i], ea, ed);
      end
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++; $display("FAIL %s_idle got=%b exp=0", tag, busy_after);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int dones;
    found = 1'b0;
    dones = 0;
    rand_data();
    pulse_start();
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (write_a && addr_a == BASE_A + 32'h14) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL rstmid_beat5 got=absent exp=present");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({write_a, busy_a, done_a} !== 3'b000 || addr_a !== BASE_A) begin
      failures++; $display("FAIL rstmid_abort got=%b/%h exp=000/%h", {write_a, busy_a, done_a}, addr_a, BASE_A);
    end
    repeat (3) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL rstmid_nodone got=%0d exp=0", dones);
    end
    rand_data();
    pulse_start();
    run_xfer(0, 0, 1'b0, 1);
    checks++;
    if (ga_addr.size() != DEPTH + 1 || ga_addr[0] !== BASE_A || ga_data[0] !== 32'(ref_c[0])) begin
      failures++; $display("FAIL rstmid_restart got=n%0d exp=n%0d at %h", ga_addr.size(), DEPTH + 1, BASE_A);
    end
    checks++;
    if (done_cyc != DEPTH + 2) begin
      failures++; $display("FAIL rstmid_done got=%0d exp=%0d", done_cyc, DEPTH + 2);
    end
  endtask

  task automatic test_base_width();
    rand_data();
    c_vector[7] = 24'hABCDEF;
    pulse_start();
    run_xfer(0, 0, 1'b0, 1);
    checks++;
    if (gb_addr.size() != DEPTH + 1) begin
      failures++; $display("FAIL base_count got=%0d exp=%0d", gb_addr.size(), DEPTH + 1);
    end else begin
      checks++;
      if ({gb_addr[7], gb_data[7]} !== {32'h101C, 32'h00ABCDEF}) begin
        failures++; $display("FAIL base_beat7 got=%h:%h exp=0000101c:00abcdef", gb_addr[7], gb_data[7]);
      end
      checks++;
      if (gb_addr[8] !== 32'h1020 || gb_data[8] !== 32'(ref_sum)) begin
        failures++; $display("FAIL base_sum got=%h:%h exp=00001020:%h", gb_addr[8], gb_data[8], 32'(ref_sum));
      end
    end
    checks++;
    if (be_bad != 0) begin
      failures++; $display("FAIL base_be got=%0d exp=0", be_bad);
    end
  endtask

  task automatic test_wrap();
    rand_data();
    pulse_start();
    run_xfer(0, 0, 1'b0, 1);
    checks++;
    if (gc_addr.size() != DEPTH + 1) begin
      failures++; $display("FAIL wrap_count got=%0d exp=%0d", gc_addr.size(), DEPTH + 1);
    end
    for (int i = 0; i < gc_addr.size() && i <= DEPTH; i++) begin
      logic [31:0] ea, ed;
      ea = BASE_C + 32'(4 * i);
      ed = (i < DEPTH) ? 32'(ref_c[i]) : 32'(ref_sum);
      checks++;
      if ({gc_addr[i], gc_data[i]} !== {ea, ed}) begin
        failures++; $display("FAIL wrap_beat%0d got=%h:%h exp=%h:%h", i, gc_addr[i], gc_data[i], ea, ed);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      rand_data();
      pulse_start();
      run_xfer(2, 0, 1'b0, 2);
      checks++;
      if (ga_addr.size() != DEPTH + 1) begin
        failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", k, ga_addr.size(), DEPTH + 1);
      end
      for (int i = 0; i < ga_addr.size() && i <= DEPTH; i++) begin
        logic [31:0] ea, ed;
        ea = BASE_A + 32'(4 * i);
        ed = (i < DEPTH) ? 32'(ref_c[i]) : 32'(ref_sum);
        checks++;
        if ({ga_addr[i], ga_data[i]} !== {ea, ed}) begin
          failures++; $display("FAIL rand%0d_beat%0d got=%h:%h exp=%h:%h", k, i, ga_addr[i], ga_data[i], ea, ed);
        end
      end
      checks++;
      if (done_cyc != DEPTH + 2 + stall_cnt || busy_cnt != done_cyc) begin
        failures++; $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d", k, done_cyc, busy_cnt, DEPTH + 2 + stall_cnt);
      end
      checks++;
      if (unstable != 0) begin
        failures++; $display("FAIL rand%0d_stable got=%0d exp=0", k, unstable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_start_busy(4, "busy");
    test_start_busy(DEPTH + 2, "b2b");
    test_reset_mid();
    test_base_width();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
